// File: rtl/sprite_fetch_scheduler_pkg.sv
// Shared definitions for the sprite fetch scheduler: attribute field
// positions, pattern address constants and scheduler state encoding.
package sprite_fetch_scheduler_pkg;

  localparam int Y_LSB   = 0;
  localparam int Y_MSB   = 8;
  localparam int X_LSB   = 9;
  localparam int X_MSB   = 18;
  localparam int IMG_LSB = 19;
  localparam int IMG_MSB = 23;
  localparam int EN_BIT  = 31;

  localparam int ROW_BITS       = 4;
  localparam int PATTERN_ADDR_W = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_CLEAR,
    S_DONE
  } state_t;

  // Row of a sprite on a scanline; 9-bit wrap so Y near 511
  // shows at the top of the screen.
  function automatic logic [8:0] row_diff(
    input logic [8:0] line,
    input logic [8:0] y
  );
    return line - y;
  endfunction

endpackage

// File: rtl/sprite_fetch_scheduler_attr_table.sv
// Sprite attribute register file: one write port, one combinational
// read port, cleared (all entries disabled) by synchronous reset.
// Ports: clk, reset, wen/waddr/wdata write, raddr/rdata read.
module sprite_attr_table #(
  parameter int NUM_SPRITES = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wen,
  input  logic [$clog2(NUM_SPRITES)-1:0] waddr,
  input  logic [31:0]                    wdata,
  input  logic [$clog2(NUM_SPRITES)-1:0] raddr,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [NUM_SPRITES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        mem[i] <= '0;
      end
    end else if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  // Read sees the pre-write value during a same-cycle write.
  assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_fetch_scheduler.sv
// Per-scanline sprite fetch scheduler: scans the attribute table,
// fetches pattern rows and writes/clears compositor slots.
// Ports: attr_* CPU writes, line_start/line trigger, mem_* pattern
// read, slot_* compositor writes, busy/done/overflow status.
module sprite_fetch_scheduler
  import sprite_fetch_scheduler_pkg::*;
#(
  parameter int NUM_SPRITES = 16,
  parameter int MAX_SLOTS   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           attr_wen,
  input  logic [$clog2(NUM_SPRITES)-1:0] attr_addr,
  input  logic [31:0]                    attr_wdata,
  input  logic                           line_start,
  input  logic [8:0]                     line,
  output logic [PATTERN_ADDR_W-1:0]      mem_raddr,
  input  logic [31:0]                    mem_rdata,
  output logic                           slot_wen,
  output logic [$clog2(MAX_SLOTS)-1:0]   slot_idx,
  output logic                           slot_valid,
  output logic [9:0]                     slot_x,
  output logic [31:0]                    slot_data,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);

  localparam int IW = $clog2(NUM_SPRITES);
  localparam int SW = $clog2(MAX_SLOTS);
  localparam int CW = SW + 1;

  state_t        state_q, state_d;
  logic [8:0]    line_q;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          ovf_out_q;
  logic          pend_q;
  logic [SW-1:0] pend_idx_q;
  logic [9:0]    pend_x_q;

  logic [31:0]   ent;
  logic [8:0]    diff;
  logic          vis;
  logic          room;
  logic          fetch;
  logic          clr;
  logic          unused_bits;

  sprite_attr_table #(
    .NUM_SPRITES(NUM_SPRITES)
  ) u_attr (
    .clk  (clk),
    .reset(reset),
    .wen  (attr_wen),
    .waddr(attr_addr),
    .wdata(attr_wdata),
    .raddr(idx_q),
    .rdata(ent)
  );

  assign unused_bits = ^ent[30:24];

  assign diff = row_diff(line_q, ent[Y_MSB:Y_LSB]);
  assign vis  = ent[EN_BIT] && (diff[8:ROW_BITS] == '0);
  assign room = cnt_q < CW'(MAX_SLOTS);

  always_comb begin
    state_d   = state_q;
    fetch     = 1'b0;
    clr       = 1'b0;
    mem_raddr = '0;
    unique case (state_q)
      S_IDLE: begin
        if (line_start) state_d = S_SCAN;
      end
      S_SCAN: begin
        fetch = vis && room;
        if (fetch) begin
          mem_raddr = {ent[IMG_MSB:IMG_LSB],
                       diff[ROW_BITS-1:0]};
        end
        if (idx_q == IW'(NUM_SPRITES - 1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = room ? S_CLEAR : S_DONE;
      end
      S_CLEAR: begin
        clr = 1'b1;
        if (cnt_q == CW'(MAX_SLOTS - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      line_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      ovf_out_q  <= 1'b0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      pend_x_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= fetch;
      if (fetch) begin
        pend_idx_q <= cnt_q[SW-1:0];
        pend_x_q   <= ent[X_MSB:X_LSB];
      end
      if (state_q == S_IDLE && line_start) begin
        line_q <= line;
        idx_q  <= '0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
      end
      if (state_q == S_SCAN) begin
        idx_q <= idx_q + IW'(1);
        if (vis && !room) ovf_q <= 1'b1;
      end
      // The slot count doubles as the clear pointer.
      if (fetch || clr) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == S_DONE) begin
        ovf_out_q <= ovf_q;
      end
    end
  end

  always_comb begin
    slot_wen   = pend_q | clr;
    slot_valid = pend_q;
    slot_idx   = '0;
    slot_x     = '0;
    slot_data  = '0;
    if (pend_q) begin
      slot_idx  = pend_idx_q;
      slot_x    = pend_x_q;
      slot_data = mem_rdata;
    end else if (clr) begin
      slot_idx = cnt_q[SW-1:0];
    end
  end

  assign busy     = state_q != S_IDLE;
  assign done     = state_q == S_DONE;
  assign overflow = ovf_out_q;

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Scoreboard bench for sprite_fetch_scheduler: a line-level model
// predicts fetches, slot writes, done and overflow per cycle.
module tb_sprite_fetch_scheduler;

  localparam int NS  = 16;
  localparam int MAX = 8;

  typedef struct {
    int         cyc;
    logic [8:0] addr;
  } fexp_t;

  typedef struct {
    int          cyc;
    logic [2:0]  idx;
    logic        v;
    logic [9:0]  x;
    logic [31:0] d;
  } sexp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        attr_wen;
  logic [3:0]  attr_addr;
  logic [31:0] attr_wdata;
  logic        line_start;
  logic [8:0]  line;
  logic [8:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic        slot_wen;
  logic [2:0]  slot_idx;
  logic        slot_valid;
  logic [9:0]  slot_x;
  logic [31:0] slot_data;
  logic        busy;
  logic        done;
  logic        overflow;

  always #5 clk = ~clk;

  sprite_fetch_scheduler #(
    .NUM_SPRITES(NS),
    .MAX_SLOTS  (MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .attr_wen  (attr_wen),
    .attr_addr (attr_addr),
    .attr_wdata(attr_wdata),
    .line_start(line_start),
    .line      (line),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .slot_wen  (slot_wen),
    .slot_idx  (slot_idx),
    .slot_valid(slot_valid),
    .slot_x    (slot_x),
    .slot_data (slot_data),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  function automatic logic [31:0] pat(input logic [8:0] a);
    return {a, ~a, a, 5'h15};
  endfunction

  // Pattern memory: registered read.
  always @(posedge clk) mem_rdata <= pat(mem_raddr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  fexp_t fq[$];
  sexp_t sq[$];
  int    dq[$];
  int    busy_lo = 1;
  int    busy_hi = 0;
  int    ovf_cyc = -1;
  logic  ovf_exp = 1'b0;
  logic [31:0] am [NS];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input bit en, input int y,
                                     input int x, input int img);
    logic [31:0] w;
    w        = '0;
    w[31]    = en;
    w[23:19] = img[4:0];
    w[18:9]  = x[9:0];
    w[8:0]   = y[8:0];
    return w;
  endfunction

  // Line-level reference: visible entries in index order take slots
  // until full; the rest of the slots are cleared afterwards.
  task automatic model(input int t, input logic [8:0] ln);
    int          cnt;
    logic [8:0]  d;
    logic [8:0]  a;
    logic [31:0] e;
    cnt     = 0;
    ovf_exp = 1'b0;
    for (int i = 0; i < NS; i++) begin
      e = am[i];
      d = (ln - e[8:0]) & 9'h1ff;
      if (e[31] && d < 16) begin
        if (cnt < MAX) begin
          a = {e[23:19], d[3:0]};
          fq.push_back('{t + 1 + i, a});
          sq.push_back('{t + 2 + i, cnt[2:0], 1'b1,
                         e[18:9], pat(a)});
          cnt++;
        end else begin
          ovf_exp = 1'b1;
        end
      end
    end
    for (int s = cnt; s < MAX; s++) begin
      sq.push_back('{t + NS + 2 + (s - cnt), s[2:0],
                     1'b0, 10'd0, 32'd0});
    end
    dq.push_back(t + NS + 2 + (MAX - cnt));
    busy_lo = t + 1;
    busy_hi = t + NS + 2 + (MAX - cnt);
  endtask

  always @(negedge clk) begin
    if (fq.size() > 0 && fq[0].cyc == cyc) begin
      chk("mem_raddr", 32'(mem_raddr), 32'(fq[0].addr));
      fq.delete(0);
    end else if (mem_raddr !== 9'd0) begin
      chk("stray_fetch", 32'(mem_raddr), 32'd0);
    end
    if (sq.size() > 0 && sq[0].cyc == cyc) begin
      chk("slot_wen", 32'(slot_wen), 32'd1);
      chk("slot_idx", 32'(slot_idx), 32'(sq[0].idx));
      chk("slot_valid", 32'(slot_valid), 32'(sq[0].v));
      chk("slot_x", 32'(slot_x), 32'(sq[0].x));
      chk("slot_data", slot_data, sq[0].d);
      sq.delete(0);
    end else if (slot_wen !== 1'b0) begin
      chk("stray_slot_wen", 32'(slot_wen), 32'd0);
    end
    if (dq.size() > 0 && dq[0] == cyc) begin
      chk("done", 32'(done), 32'd1);
      ovf_cyc = cyc + 1;
      dq.delete(0);
    end else if (done !== 1'b0) begin
      chk("stray_done", 32'(done), 32'd0);
    end
    if (cyc == ovf_cyc) begin
      chk("overflow", 32'(overflow), 32'(ovf_exp));
    end
    chk("busy", 32'(busy),
        32'(cyc >= busy_lo && cyc <= busy_hi));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int i, input logic [31:0] w);
    attr_wen   = 1'b1;
    attr_addr  = i[3:0];
    attr_wdata = w;
    tick();
    attr_wen   = 1'b0;
    am[i]      = w;
  endtask

  task automatic clear_table;
    for (int i = 0; i < NS; i++) wr(i, 32'd0);
  endtask

  task automatic run_line(input logic [8:0] ln, input bit restart);
    line_start = 1'b1;
    line       = ln;
    model(cyc, ln);
    tick();
    line_start = 1'b0;
    if (restart) begin
      repeat (3) tick();
      line_start = 1'b1;
      line       = ln + 9'd1;
      tick();
      line_start = 1'b0;
    end
    repeat (NS + MAX + 4) tick();
    chk("leftover", fq.size() + sq.size() + dq.size(), 0);
    fq.delete();
    sq.delete();
    dq.delete();
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    chk({tag, "_zero"},
        {22'd0, slot_wen, slot_valid, busy, done,
         overflow, |slot_idx, |slot_x, |slot_data,
         |mem_raddr, 1'b0}, 32'd0);
    tick();
  endtask

  initial begin
    int t;
    int ln;
    fexp_t fk[$];
    sexp_t sk[$];
    reset      = 1'b1;
    attr_wen   = 1'b0;
    attr_addr  = '0;
    attr_wdata = '0;
    line_start = 1'b0;
    line       = '0;
    for (int i = 0; i < NS; i++) am[i] = '0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Single sprite at Y=100, line 105.
    wr(0, mk(1, 100, 40, 3));
    run_line(9'd105, 0);

    // Wrap: Y=510 on line 4 is row 6.
    clear_table();
    wr(0, mk(1, 510, 7, 5));
    run_line(9'd4, 0);

    // Boundary rows.
    clear_table();
    wr(2, mk(1, 100, 12, 9));
    run_line(9'd115, 0);
    run_line(9'd116, 0);
    run_line(9'd99, 0);

    // Overflow: ten sprites on one line.
    clear_table();
    for (int i = 0; i < 10; i++) wr(i, mk(1, 200, i * 10, i + 1));
    run_line(9'd205, 0);

    // All disabled, with a stray restart while busy.
    clear_table();
    for (int i = 0; i < NS; i++) wr(i, mk(0, 50, i, 2));
    run_line(9'd52, 1);

    // Randomized tables and lines.
    for (int n = 0; n < 20; n++) begin
      ln = $urandom_range(0, 511);
      for (int i = 0; i < NS; i++) begin
        logic [31:0] w;
        w = mk($urandom_range(0, 3) != 0,
               (ln - $urandom_range(0, 20)) & 511,
               $urandom_range(0, 1023),
               $urandom_range(1, 31));
        w[30:24] = 7'($urandom);
        wr(i, w);
      end
      run_line(ln[8:0], 0);
    end

    // Reset mid-scan.
    for (int i = 0; i < NS; i++) wr(i, mk(1, 300, i, i + 1));
    t = cyc;
    line_start = 1'b1;
    line       = 9'd303;
    model(t, 9'd303);
    tick();
    line_start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    fk = fq;
    sk = sq;
    fq.delete();
    sq.delete();
    foreach (fk[i]) if (fk[i].cyc <= t + 5) fq.push_back(fk[i]);
    foreach (sk[i]) if (sk[i].cyc <= t + 5) sq.push_back(sk[i]);
    dq.delete();
    busy_hi = t + 5;
    ovf_exp = 1'b0;
    ovf_cyc = t + 6;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NS; i++) am[i] = '0;
    check_all_zero("mid_reset");
    repeat (NS + MAX + 4) tick();
    chk("reset_leftover", fq.size() + sq.size() + dq.size(), 0);
    fq.delete();
    sq.delete();
    run_line(9'd303, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
